// File: rtl/collision_engine.sv
// Purpose : per-frame ball/paddle collision check with hit holdoff, saturating score,
//           and optional wall/miss detection (enabled by macro COLLISION_WALL_EN).
// Latency : frame_tick at edge E -> hit visible in the cycle after edge E+NUM_PADDLES+1.
// Backpressure: none; frame_tick arriving while busy=1 is dropped with no side effect.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   frame_tick             one-cycle pulse per video frame, starts a check
//   ball_row/ball_col      ball top-left corner (COORD_W each)
//   paddle_row/paddle_col  paddle i in bits [i*COORD_W +: COORD_W]
//   hit, hit_idx           accepted-collision pulse and lowest matching paddle (held)
//   score                  saturating count of accepted hits
//   busy                   high from coordinate latch to end of REPORT
//   wall_hit, miss         wall/miss pulses (constant 0 unless COLLISION_WALL_EN)
module collision_engine #(
  parameter int COORD_W     = 16,
  parameter int NUM_PADDLES = 2,
  parameter int BALL_SIZE   = 8,
  parameter int PAD_W       = 8,
  parameter int PAD_H       = 32,
  parameter int HOLDOFF     = 4,
  parameter int SCORE_W     = 8,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  localparam int IDX_W      = (NUM_PADDLES > 1) ? $clog2(NUM_PADDLES) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           frame_tick,
  input  logic [COORD_W-1:0]             ball_row,
  input  logic [COORD_W-1:0]             ball_col,
  input  logic [NUM_PADDLES*COORD_W-1:0] paddle_row,
  input  logic [NUM_PADDLES*COORD_W-1:0] paddle_col,
  output logic                           hit,
  output logic [IDX_W-1:0]               hit_idx,
  output logic [SCORE_W-1:0]             score,
  output logic                           busy,
  output logic                           wall_hit,
  output logic                           miss
);

  localparam int SUM_W = COORD_W + 1;
  localparam int HO_W  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PADDLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_REPORT} state_t;

  state_t                         state_q, state_d;
  logic [COORD_W-1:0]             ball_row_q, ball_row_d;
  logic [COORD_W-1:0]             ball_col_q, ball_col_d;
  logic [NUM_PADDLES*COORD_W-1:0] prow_q, prow_d;
  logic [NUM_PADDLES*COORD_W-1:0] pcol_q, pcol_d;
  logic [IDX_W-1:0]               scan_idx_q, scan_idx_d;
  logic                           match_q, match_d;
  logic [IDX_W-1:0]               match_idx_q, match_idx_d;
  logic                           suppress_q, suppress_d;
  logic [HO_W-1:0]                holdoff_q, holdoff_d;
  logic                           hit_q, hit_d;
  logic [IDX_W-1:0]               hit_idx_q, hit_idx_d;
  logic [SCORE_W-1:0]             score_q, score_d;
  logic                           busy_q, busy_d;
  logic                           wall_hit_q, wall_hit_d;
  logic                           miss_q, miss_d;

  // Overlap test for the paddle under the scan index; one extra bit keeps
  // coordinate+size sums from wrapping near the top of the coordinate range.
  logic [COORD_W-1:0] cur_prow, cur_pcol;
  logic [SUM_W-1:0]   b_row_x, b_col_x, p_row_x, p_col_x;
  logic               overlap;

  always_comb begin
    cur_prow = prow_q[int'(scan_idx_q)*COORD_W +: COORD_W];
    cur_pcol = pcol_q[int'(scan_idx_q)*COORD_W +: COORD_W];
    b_row_x  = {1'b0, ball_row_q};
    b_col_x  = {1'b0, ball_col_q};
    p_row_x  = {1'b0, cur_prow};
    p_col_x  = {1'b0, cur_pcol};
    overlap  = (b_col_x < p_col_x + SUM_W'(PAD_W))     &&
               (p_col_x < b_col_x + SUM_W'(BALL_SIZE)) &&
               (b_row_x < p_row_x + SUM_W'(PAD_H))     &&
               (p_row_x < b_row_x + SUM_W'(BALL_SIZE));
  end

`ifdef COLLISION_WALL_EN
  logic wall_edge, side_edge;
  always_comb begin
    wall_edge = (ball_row_q == '0) ||
                (b_row_x + SUM_W'(BALL_SIZE) >= SUM_W'(SCREEN_H));
    side_edge = (ball_col_q == '0) ||
                (b_col_x + SUM_W'(BALL_SIZE) >= SUM_W'(SCREEN_W));
  end
`endif

  always_comb begin
    state_d     = state_q;
    ball_row_d  = ball_row_q;
    ball_col_d  = ball_col_q;
    prow_d      = prow_q;
    pcol_d      = pcol_q;
    scan_idx_d  = scan_idx_q;
    match_d     = match_q;
    match_idx_d = match_idx_q;
    suppress_d  = suppress_q;
    holdoff_d   = holdoff_q;
    hit_d       = 1'b0;
    hit_idx_d   = hit_idx_q;
    score_d     = score_q;
    wall_hit_d  = 1'b0;
    miss_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          ball_row_d = ball_row;
          ball_col_d = ball_col;
          prow_d     = paddle_row;
          pcol_d     = paddle_col;
          match_d    = 1'b0;
          scan_idx_d = '0;
          // The gate for this frame is taken from the counter before it is
          // decremented, so exactly HOLDOFF frames after a hit are suppressed.
          suppress_d = (holdoff_q != '0);
          if (holdoff_q != '0) holdoff_d = holdoff_q - 1'b1;
          state_d    = S_SCAN;
        end
      end
      S_SCAN: begin
        if (overlap && !match_q) begin
          match_d     = 1'b1;
          match_idx_d = scan_idx_q;
        end
        if (scan_idx_q == LAST_IDX) state_d = S_REPORT;
        else                        scan_idx_d = scan_idx_q + 1'b1;
      end
      S_REPORT: begin
        if (match_q && !suppress_q) begin
          hit_d     = 1'b1;
          hit_idx_d = match_idx_q;
          score_d   = (score_q == '1) ? score_q : score_q + 1'b1;
          holdoff_d = HO_W'(HOLDOFF);
        end
`ifdef COLLISION_WALL_EN
        wall_hit_d = wall_edge;
        miss_d     = side_edge && !match_q;
        if (side_edge && !match_q) score_d = '0;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ball_row_q  <= '0;
      ball_col_q  <= '0;
      prow_q      <= '0;
      pcol_q      <= '0;
      scan_idx_q  <= '0;
      match_q     <= 1'b0;
      match_idx_q <= '0;
      suppress_q  <= 1'b0;
      holdoff_q   <= '0;
      hit_q       <= 1'b0;
      hit_idx_q   <= '0;
      score_q     <= '0;
      busy_q      <= 1'b0;
      wall_hit_q  <= 1'b0;
      miss_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ball_row_q  <= ball_row_d;
      ball_col_q  <= ball_col_d;
      prow_q      <= prow_d;
      pcol_q      <= pcol_d;
      scan_idx_q  <= scan_idx_d;
      match_q     <= match_d;
      match_idx_q <= match_idx_d;
      suppress_q  <= suppress_d;
      holdoff_q   <= holdoff_d;
      hit_q       <= hit_d;
      hit_idx_q   <= hit_idx_d;
      score_q     <= score_d;
      busy_q      <= busy_d;
      wall_hit_q  <= wall_hit_d;
      miss_q      <= miss_d;
    end
  end

  assign hit      = hit_q;
  assign hit_idx  = hit_idx_q;
  assign score    = score_q;
  assign busy     = busy_q;
  assign wall_hit = wall_hit_q;
  assign miss     = miss_q;

endmodule

// File: tb/tb_collision_engine.sv
// Purpose : directed checks of collision_engine with default parameters.
// Latency : each frame is observed for 8 cycles after its tick edge.
// Backpressure: frames are spaced so the engine is always idle at the next tick.
module tb_collision_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic [15:0] ball_row, ball_col;
  logic [31:0] paddle_row, paddle_col;
  logic        hit;
  logic [0:0]  hit_idx;
  logic [7:0]  score;
  logic        busy, wall_hit, miss;

  int total = 0;
  int bad   = 0;

  collision_engine dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .ball_row(ball_row), .ball_col(ball_col),
    .paddle_row(paddle_row), .paddle_col(paddle_col),
    .hit(hit), .hit_idx(hit_idx), .score(score), .busy(busy),
    .wall_hit(wall_hit), .miss(miss)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic place(input logic [15:0] br, input logic [15:0] bc,
                       input logic [15:0] p0r, input logic [15:0] p0c,
                       input logic [15:0] p1r, input logic [15:0] p1c);
    ball_row   = br;
    ball_col   = bc;
    paddle_row = {p1r, p0r};
    paddle_col = {p1c, p0c};
  endtask

  // Tick held for tick_len samples; rst pulsed for one cycle at sample rst_at (0 = never).
  // k counts negedges after the tick edge; hit_k is the first sample showing hit.
  task automatic frame(input int tick_len, input int rst_at,
                       output int nhit, output int hit_k, output int nbusy,
                       output int nwall, output int nmiss);
    nhit = 0; hit_k = 0; nbusy = 0; nwall = 0; nmiss = 0;
    @(negedge clk);
    frame_tick = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (hit) begin
        nhit++;
        if (hit_k == 0) hit_k = k;
      end
      if (busy)     nbusy++;
      if (wall_hit) nwall++;
      if (miss)     nmiss++;
      frame_tick = (k < tick_len);
      if (k == rst_at) rst = 1'b1;
      else             rst = 1'b0;
    end
  endtask

  task automatic quiet(input int n);
    int h, hk, b, w, m;
    place(16'd200, 16'd300, 16'd10, 16'd10, 16'd400, 16'd600);
    for (int i = 0; i < n; i++) frame(1, 0, h, hk, b, w, m);
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  int nh, hk, nb, nw, nm;
  int exp_wrap_score;

  initial begin
    rst = 1'b1; frame_tick = 1'b0;
    place(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    repeat (2) @(negedge clk);
    check("rst_hit",   32'(hit),      0);
    check("rst_busy",  32'(busy),     0);
    check("rst_score", 32'(score),    0);
    check("rst_idx",   32'(hit_idx),  0);
    check("rst_wall",  32'(wall_hit), 0);
    check("rst_miss",  32'(miss),     0);
    rst = 1'b0;

    // Basic hit and its timing.
    place(16'd100, 16'd100, 16'd90, 16'd96, 16'd400, 16'd600);
    frame(1, 0, nh, hk, nb, nw, nm);
    check("basic_nhit",  nh, 1);
    check("basic_lat",   hk, 4);
    check("basic_busy",  nb, 3);
    check("basic_idx",   32'(hit_idx), 0);
    check("basic_score", 32'(score), 1);

    // Reset during SCAN aborts the frame and clears holdoff/score.
    frame(1, 1, nh, hk, nb, nw, nm);
    check("rstscan_nhit",  nh, 0);
    check("rstscan_busy",  32'(busy), 0);
    check("rstscan_score", 32'(score), 0);
    frame(1, 0, nh, hk, nb, nw, nm);
    check("postrst_nhit",  nh, 1);
    check("postrst_score", 32'(score), 1);

    // Both paddles overlap, tick held 3 cycles: lowest index, one frame only.
    quiet(4);
    place(16'd100, 16'd100, 16'd90, 16'd96, 16'd95, 16'd98);
    frame(3, 0, nh, hk, nb, nw, nm);
    check("both_nhit",  nh, 1);
    check("both_busy",  nb, 3);
    check("both_idx",   32'(hit_idx), 0);
    check("both_score", 32'(score), 2);

    // Only paddle 1 overlaps.
    quiet(4);
    place(16'd100, 16'd100, 16'd400, 16'd600, 16'd90, 16'd96);
    frame(1, 0, nh, hk, nb, nw, nm);
    check("p1_nhit",  nh, 1);
    check("p1_idx",   32'(hit_idx), 1);
    check("p1_score", 32'(score), 3);
    quiet(4);
    check("idx_held", 32'(hit_idx), 1);

    // Six consecutive overlapping frames: hits on the 1st and 6th only.
    place(16'd100, 16'd100, 16'd90, 16'd96, 16'd400, 16'd600);
    for (int f = 1; f <= 6; f++) begin
      frame(1, 0, nh, hk, nb, nw, nm);
      check($sformatf("holdoff_f%0d", f), nh, (f == 1 || f == 6) ? 1 : 0);
    end
    check("holdoff_score", 32'(score), 5);

    // Ball near the top of the coordinate range must not wrap into a match.
    quiet(4);
    place(16'd100, 16'd65530, 16'd100, 16'd2, 16'd400, 16'd600);
    frame(1, 0, nh, hk, nb, nw, nm);
    check("wrap_nhit", nh, 0);
`ifdef COLLISION_WALL_EN
    exp_wrap_score = 0;
`else
    exp_wrap_score = 5;
`endif
    check("wrap_score", 32'(score), 32'(exp_wrap_score));

    // Wall corner with score 3 and no paddle overlap.
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      place(16'd100, 16'd100, 16'd90, 16'd96, 16'd400, 16'd600);
      frame(1, 0, nh, hk, nb, nw, nm);
      quiet(4);
    end
    check("wall_pre_score", 32'(score), 3);
    place(16'd0, 16'd632, 16'd200, 16'd10, 16'd300, 16'd20);
    frame(1, 0, nh, hk, nb, nw, nm);
    check("wall_nhit", nh, 0);
`ifdef COLLISION_WALL_EN
    check("wall_pulse",  nw, 1);
    check("miss_pulse",  nm, 1);
    check("wall_score",  32'(score), 0);
`else
    check("wall_pulse",  nw, 0);
    check("miss_pulse",  nm, 0);
    check("wall_score",  32'(score), 3);
`endif

    // Score saturation at 255.
    pulse_reset();
    for (int i = 0; i < 255; i++) begin
      place(16'd100, 16'd100, 16'd90, 16'd96, 16'd400, 16'd600);
      frame(1, 0, nh, hk, nb, nw, nm);
      quiet(4);
    end
    check("sat_reach", 32'(score), 255);
    place(16'd100, 16'd100, 16'd90, 16'd96, 16'd400, 16'd600);
    frame(1, 0, nh, hk, nb, nw, nm);
    check("sat_nhit",  nh, 1);
    check("sat_score", 32'(score), 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/collision_engine.md
COLLISION_ENGINE -- requirements
Module: collision_engine

Interface
REQ-001 SHALL provide parameter COORD_W, default 16, coordinate width in bits.
REQ-002 SHALL provide parameter NUM_PADDLES, default 2, number of paddles checked per frame (1..8).
REQ-003 SHALL provide parameter BALL_SIZE, default 8, ball edge length in pixels.
REQ-004 SHALL provide parameters PAD_W, default 8, and PAD_H, default 32, paddle width and height in pixels.
REQ-005 SHALL provide parameter HOLDOFF, default 4, number of frames after a hit during which further hits are suppressed.
REQ-006 SHALL provide parameter SCORE_W, default 8, score counter width.
REQ-007 SHALL provide parameters SCREEN_W, default 640, and SCREEN_H, default 480, play-field size; these are used only under REQ-027.
REQ-008 SHALL run on one clock with an asynchronous, active-high reset, on ports clk (input, 1) and rst (input, 1).
REQ-009 SHALL have frame_tick (input, 1): one-cycle pulse per video frame.
REQ-010 SHALL have ball_row and ball_col (input, COORD_W each): ball top-left corner.
REQ-011 SHALL have paddle_row and paddle_col (input, NUM_PADDLES*COORD_W each): paddle i occupies bits [i*COORD_W +: COORD_W].
REQ-012 SHALL have hit (output, 1): one-cycle pulse on an accepted paddle collision.
REQ-013 SHALL have hit_idx (output, clog2(NUM_PADDLES), minimum 1 bit): index of the paddle hit; valid while hit=1 and held afterwards.
REQ-014 SHALL have score (output, SCORE_W): count of accepted hits.
REQ-015 SHALL have busy (output, 1): high from coordinate latch until the end of REPORT.
REQ-016 SHALL have wall_hit and miss (output, 1 each): one-cycle pulses defined in REQ-027.

Function
REQ-017 SHALL implement an FSM with states IDLE, SCAN and REPORT.
REQ-018 IDLE with frame_tick=1 SHALL latch all ball and paddle coordinates, clear the match flag, set the scan index to 0, and move to SCAN.
REQ-019 SCAN SHALL test one paddle per cycle, index 0 to NUM_PADDLES-1, then move to REPORT.
REQ-020 Overlap SHALL be ball_col < pcol+PAD_W and pcol < ball_col+BALL_SIZE and ball_row < prow+PAD_H and prow < ball_row+BALL_SIZE.
REQ-021 All overlap sums SHALL be computed in COORD_W+1 bits, so they never wrap.
REQ-022 The first (lowest) matching index SHALL be recorded; later matches in the same frame SHALL be ignored.
REQ-023 REPORT SHALL last one cycle and then return to IDLE.
REQ-024 In REPORT, if there is a match and the holdoff counter is 0:
- hit=1 and hit_idx is updated
- score increments, saturating at all-ones
- the holdoff counter loads HOLDOFF.
REQ-025 The holdoff counter SHALL decrement by 1 at each accepted frame_tick (REQ-018) while it is nonzero; a match while the counter is nonzero SHALL produce no hit and no score change.
REQ-026 Latency: frame_tick sampled at edge E SHALL give hit high in the cycle after edge E+NUM_PADDLES+1; frame_tick while busy=1 SHALL be ignored with no other effect.

Reset
REQ-028 rst=1 SHALL force, asynchronously: state IDLE; hit, wall_hit, miss, busy, hit_idx, score, holdoff counter and latched coordinates to 0.
REQ-029 Reset asserted mid-SCAN or in REPORT SHALL abort the frame with no pulse generated; the first frame_tick after release SHALL be processed normally.

Configuration
REQ-027 With macro COLLISION_WALL_EN defined, REPORT SHALL also evaluate the latched ball position:
- wall_hit=1 if ball_row==0 or ball_row+BALL_SIZE>=SCREEN_H
- miss=1 if (ball_col==0 or ball_col+BALL_SIZE>=SCREEN_W) and no paddle matched; miss SHALL also clear score to 0.
Without the macro, wall_hit and miss SHALL be constant 0, and SCREEN_W/SCREEN_H SHALL have no effect.

Verification
REQ-030 Defaults, ball (100,100), paddle0 (90,96), frame_tick -> hit=1 with hit_idx=0 exactly 4 cycles after the tick edge, score=1, busy high for 3 cycles.
REQ-031 Ball overlapping both paddle0 and paddle1 -> hit_idx=0, single hit pulse, score increments by 1.
REQ-032 Overlap held on 6 consecutive frames, HOLDOFF=4 -> hits on frames 1 and 6 only; score=2.
REQ-033 Ball col 65530 with paddle col 2 -> no hit (no wrap-around match); score=255 plus one accepted hit -> score stays 255.
REQ-034 rst pulsed during SCAN -> no hit, score=0, busy=0; next frame with overlap -> hit, score=1.
REQ-035 COLLISION_WALL_EN defined, ball (0,632), no paddle overlap, score=3 -> wall_hit=1, miss=1, score=0; macro undefined -> wall_hit=0, miss=0, score=3.
